// File: rtl/fpu_pkg.sv
// ============================================================================
// Module  : fpu_pkg
// Brief   : Shared FP32 field constants, flag and class types for the FPU.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fpu_pkg;

   localparam int          EXP_W     = 8;
   localparam int          FRAC_W    = 23;
   localparam int          BIAS      = 127;
   localparam logic [31:0] CANON_NAN = 32'h7FC00000;

   typedef struct packed {
      logic nv;
      logic of;
      logic uf;
   } fflags_t;

   typedef enum logic [1:0] {
      NORMAL  = 2'd0,
      ZERO    = 2'd1,
      SUBNORM = 2'd2,
      SPECIAL = 2'd3
   } fp_class_t;

endpackage

`default_nettype wire

// File: rtl/fp32_classify.sv
// ============================================================================
// Module  : fp32_classify
// Brief   : Combinational decode of an FP32 value into NaN/inf/zero/subnormal.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fp32_classify
   import fpu_pkg::*;
(
   input  logic [31:0] value,
   output logic        is_nan,
   output logic        is_inf,
   output logic        is_zero,
   output logic        is_subnorm
);

   logic [EXP_W-1:0]  w_exp;
   logic [FRAC_W-1:0] w_frac;
   logic              w_exp_max;
   logic              w_exp_min;
   logic              w_frac_nz;

   assign w_exp     = value[FRAC_W +: EXP_W];
   assign w_frac    = value[FRAC_W-1:0];
   assign w_exp_max = &w_exp;
   assign w_exp_min = ~|w_exp;
   assign w_frac_nz = |w_frac;

   assign is_nan     = w_exp_max &  w_frac_nz;
   assign is_inf     = w_exp_max & ~w_frac_nz;
   assign is_zero    = w_exp_min & ~w_frac_nz;
   assign is_subnorm = w_exp_min &  w_frac_nz;

endmodule

`default_nettype wire

// File: rtl/fpu_sub_result_stage.sv
// ============================================================================
// Module  : fpu_sub_result_stage
// Brief   : Registers subtraction results with IEEE flags/class into a 2-entry
//           skid FIFO toward writeback; keeps sticky accumulated flags.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_sub_result_stage
   import fpu_pkg::*;
#(
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             nRST,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data1,
   input  logic [31:0]      in_data2,
   input  logic [31:0]      in_result,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic [2:0]       out_flags,
   output logic [1:0]       out_class,
   input  logic             fflags_clr,
   output logic [2:0]       fflags
);

   logic w_d1_nan, w_d1_inf, w_d1_zero, w_d1_sub;
   logic w_d2_nan, w_d2_inf, w_d2_zero, w_d2_sub;
   logic w_rs_nan, w_rs_inf, w_rs_zero, w_rs_sub;

   fp32_classify u_cls_d1 (
      .value      (in_data1),
      .is_nan     (w_d1_nan),
      .is_inf     (w_d1_inf),
      .is_zero    (w_d1_zero),
      .is_subnorm (w_d1_sub)
   );

   fp32_classify u_cls_d2 (
      .value      (in_data2),
      .is_nan     (w_d2_nan),
      .is_inf     (w_d2_inf),
      .is_zero    (w_d2_zero),
      .is_subnorm (w_d2_sub)
   );

   fp32_classify u_cls_rs (
      .value      (in_result),
      .is_nan     (w_rs_nan),
      .is_inf     (w_rs_inf),
      .is_zero    (w_rs_zero),
      .is_subnorm (w_rs_sub)
   );

   // Operand zero/subnormal status does not influence any flag.
   logic w_unused_opnd;
   assign w_unused_opnd = ^{w_d1_zero, w_d1_sub, w_d2_zero, w_d2_sub};

   fflags_t     w_flags;
   fp_class_t   w_class;
   logic [31:0] w_stored;
   logic        w_canon;

   always_comb begin
      w_flags.nv = w_d1_nan | w_d2_nan
                 | (w_d1_inf & w_d2_inf & (in_data1[31] == in_data2[31]));
      w_flags.of = w_rs_inf & ~(w_d1_nan | w_d1_inf | w_d2_nan | w_d2_inf);
      w_flags.uf = w_rs_sub;
      w_canon    = w_flags.nv | w_rs_nan;
      w_stored   = w_canon ? CANON_NAN : in_result;
      // Class of the stored value: canonical NaN and inf both land in SPECIAL.
      if (w_canon | w_rs_inf) begin
         w_class = SPECIAL;
      end else if (w_rs_zero) begin
         w_class = ZERO;
      end else if (w_rs_sub) begin
         w_class = SUBNORM;
      end else begin
         w_class = NORMAL;
      end
   end

   logic [1:0]       r_count;
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [31:0]      r_result [2];
   logic [TAG_W-1:0] r_tag    [2];
   logic [2:0]       r_flags  [2];
   logic [1:0]       r_class  [2];
   logic [2:0]       r_fflags;

   logic w_push;
   logic w_pop;

   assign in_ready  = (r_count != 2'd2);
   assign out_valid = (r_count != 2'd0);
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         r_count  <= 2'd0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_fflags <= 3'b000;
         for (int i = 0; i < 2; i++) begin
            r_result[i] <= '0;
            r_tag[i]    <= '0;
            r_flags[i]  <= '0;
            r_class[i]  <= '0;
         end
      end else begin
         if (w_push) begin
            r_result[r_wr_ptr] <= w_stored;
            r_tag[r_wr_ptr]    <= in_tag;
            r_flags[r_wr_ptr]  <= w_flags;
            r_class[r_wr_ptr]  <= w_class;
            r_wr_ptr           <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
         // A clear coinciding with a pop keeps only the popped entry's flags.
         if (w_pop | fflags_clr) begin
            r_fflags <= (fflags_clr ? 3'b000 : r_fflags)
                      | (w_pop ? r_flags[r_rd_ptr] : 3'b000);
         end
      end
   end

   assign out_result = out_valid ? r_result[r_rd_ptr] : 32'h0;
   assign out_tag    = out_valid ? r_tag[r_rd_ptr]    : '0;
   assign out_flags  = out_valid ? r_flags[r_rd_ptr]  : 3'b000;
   assign out_class  = out_valid ? r_class[r_rd_ptr]  : 2'b00;
   assign fflags     = r_fflags;

endmodule

`default_nettype wire
